// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract/compare unit: op codes,
// default geometry and parameter legality helpers.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_EQ  = 2'b10,
    OP_GT  = 2'b11
  } op_e;

  localparam int unsigned N_DEFAULT   = 32;
  localparam int unsigned SEG_DEFAULT = 8;
  localparam int unsigned STAGES      = N_DEFAULT / SEG_DEFAULT;

  function automatic int unsigned stages_of(input int unsigned n, input int unsigned seg);
    return n / seg;
  endfunction

  // Slices are built from 4-bit lookahead groups and must tile the operand exactly.
  function automatic bit params_ok(input int unsigned n, input int unsigned seg);
    return (seg != 0) && (seg % 4 == 0) && (n % seg == 0) && (n >= seg);
  endfunction

endpackage

// File: rtl/addsub_pipe_slice.sv
// SEG-bit carry-lookahead adder slice built from chained 4-bit lookahead groups.
module addsub_pipe_slice #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_cin,
  output logic [SEG-1:0] o_sum,
  output logic           o_cout
);

  localparam int unsigned Groups = SEG / 4;

  for (genvar gi = 0; gi < Groups; gi++) begin : g_grp
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic       w_cin;
    logic [4:1] w_c;

    if (gi == 0) begin : g_first
      assign w_cin = i_cin;
    end else begin : g_chain
      assign w_cin = g_grp[gi-1].w_c[4];
    end

    assign w_g = i_a[gi*4 +: 4] & i_b[gi*4 +: 4];
    assign w_p = i_a[gi*4 +: 4] ^ i_b[gi*4 +: 4];

    // Every carry is expanded from the group carry-in so no carry waits on its neighbour.
    assign w_c[1] = w_g[0] | (w_p[0] & w_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0]) |
                    (w_p[2] & w_p[1] & w_p[0] & w_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1]) |
                    (w_p[3] & w_p[2] & w_p[1] & w_g[0]) |
                    (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_cin);

    assign o_sum[gi*4 +: 4] = w_p ^ {w_c[3:1], w_cin};
  end

  assign o_cout = g_grp[Groups-1].w_c[4];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract/compare unit: one SEG-bit slice per stage, carry registered between
// stages, whole-pipeline stall driven by the output handshake.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned N   = 32,
  parameter int unsigned SEG = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [1:0]   i_in_op,
  input  logic [N-1:0] i_in_a,
  input  logic [N-1:0] i_in_b,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [N-1:0] o_out_res,
  output logic         o_out_cout,
  output logic         o_out_ovf,
  output logic         o_out_zero
);

  localparam int unsigned Stages = stages_of(N, SEG);
  localparam int unsigned Last   = Stages - 1;

  if (!params_ok(N, SEG)) begin : g_param_check
    $error("addsub_pipe: N must be a multiple of SEG and SEG a multiple of 4");
  end

  // Per-stage registers. Operands shift down by SEG each stage so the next slice is always
  // at the bottom; the sum shifts down as slices are prepended at the top, which lines all
  // slices of a beat up at the last stage.
  logic         r_v   [Stages];
  op_e          r_op  [Stages];
  logic         r_sa  [Stages];
  logic         r_sb  [Stages];
  logic         r_c   [Stages];
  logic [N-1:0] r_a   [Stages];
  logic [N-1:0] r_b   [Stages];
  logic [N-1:0] r_sum [Stages];

  logic [N-1:0] r_res;
  logic         r_cout;
  logic         r_ovf;
  logic         r_zero;

  // Stage inputs: the ports for stage 0, the previous stage register otherwise.
  logic           w_v_in      [Stages];
  op_e            w_op_in     [Stages];
  logic           w_sa_in     [Stages];
  logic           w_sb_in     [Stages];
  logic           w_cin       [Stages];
  logic [N-1:0]   w_a_in      [Stages];
  logic [N-1:0]   w_b_in      [Stages];
  logic [N-1:0]   w_prev_sum  [Stages];
  logic [SEG-1:0] w_slice_sum [Stages];
  logic           w_slice_cout[Stages];
  logic [N-1:0]   w_sum_full  [Stages];

  logic         w_adv;
  op_e          w_op0;
  logic [N-1:0] w_b_eff;

  assign w_adv   = ~r_v[Last] | i_out_ready;
  assign w_op0   = op_e'(i_in_op);
  // SUB, EQ and GT all compute a + ~b + 1.
  assign w_b_eff = (w_op0 == OP_ADD) ? i_in_b : ~i_in_b;

  for (genvar k = 0; k < Stages; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_v_in[k]     = i_in_valid;
      assign w_op_in[k]    = w_op0;
      assign w_sa_in[k]    = i_in_a[N-1];
      assign w_sb_in[k]    = w_b_eff[N-1];
      assign w_cin[k]      = (w_op0 != OP_ADD);
      assign w_a_in[k]     = i_in_a;
      assign w_b_in[k]     = w_b_eff;
      assign w_prev_sum[k] = '0;
    end else begin : g_body
      assign w_v_in[k]     = r_v[k-1];
      assign w_op_in[k]    = r_op[k-1];
      assign w_sa_in[k]    = r_sa[k-1];
      assign w_sb_in[k]    = r_sb[k-1];
      assign w_cin[k]      = r_c[k-1];
      assign w_a_in[k]     = r_a[k-1];
      assign w_b_in[k]     = r_b[k-1];
      assign w_prev_sum[k] = r_sum[k-1];
    end

    addsub_pipe_slice #(
      .SEG(SEG)
    ) u_slice (
      .i_a   (w_a_in[k][SEG-1:0]),
      .i_b   (w_b_in[k][SEG-1:0]),
      .i_cin (w_cin[k]),
      .o_sum (w_slice_sum[k]),
      .o_cout(w_slice_cout[k])
    );

    if (Stages == 1) begin : g_single
      assign w_sum_full[k] = w_slice_sum[k];
    end else begin : g_multi
      assign w_sum_full[k] = {w_slice_sum[k], w_prev_sum[k][N-1:SEG]};
    end
  end

  // Final-stage result and flag formation.
  logic [N-1:0] w_s;
  logic [N-1:0] w_res;
  logic         w_diff_zero;
  logic         w_ovf;
  logic         w_res_cout;
  logic         w_res_ovf;
  logic         w_res_zero;

  always_comb begin
    w_s         = w_sum_full[Last];
    w_diff_zero = (w_s == '0);
    w_ovf       = (w_sa_in[Last] == w_sb_in[Last]) && (w_s[N-1] != w_sa_in[Last]);
    w_res       = w_s;
    w_res_cout  = w_slice_cout[Last];
    w_res_ovf   = w_ovf;
    unique case (w_op_in[Last])
      OP_ADD, OP_SUB: begin
      end
      OP_EQ: begin
        w_res      = {{(N-1){1'b0}}, w_diff_zero};
        w_res_cout = 1'b0;
        w_res_ovf  = 1'b0;
      end
      OP_GT: begin
        // a > b signed when the difference is non-zero and its true sign is positive.
        w_res      = {{(N-1){1'b0}}, ~w_diff_zero & ~(w_s[N-1] ^ w_ovf)};
        w_res_cout = 1'b0;
        w_res_ovf  = 1'b0;
      end
      default: begin
      end
    endcase
    w_res_zero = (w_res == '0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < Stages; k++) begin
        r_v[k]   <= 1'b0;
        r_op[k]  <= OP_ADD;
        r_sa[k]  <= 1'b0;
        r_sb[k]  <= 1'b0;
        r_c[k]   <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
      r_res  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < Stages; k++) begin
        r_v[k]   <= w_v_in[k];
        r_op[k]  <= w_op_in[k];
        r_sa[k]  <= w_sa_in[k];
        r_sb[k]  <= w_sb_in[k];
        r_c[k]   <= w_slice_cout[k];
        r_a[k]   <= w_a_in[k] >> SEG;
        r_b[k]   <= w_b_in[k] >> SEG;
        r_sum[k] <= w_sum_full[k];
      end
      r_res  <= w_res;
      r_cout <= w_res_cout;
      r_ovf  <= w_res_ovf;
      r_zero <= w_res_zero;
    end
  end

  assign o_in_ready  = w_adv;
  assign o_out_valid = r_v[Last];
  assign o_out_res   = r_res;
  assign o_out_cout  = r_cout;
  assign o_out_ovf   = r_ovf;
  assign o_out_zero  = r_zero;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: directed vector table, stall/reset sequences and a
// randomized sweep on a 16-bit instance, all checked against a plain-arithmetic model.
module tb_addsub_pipe;
  import addsub_pkg::*;

  logic clk;
  logic rst;

  logic        i32_valid, i32_rdy, o32_in_ready, o32_valid;
  logic [1:0]  i32_op;
  logic [31:0] i32_a, i32_b, o32_res;
  logic        o32_cout, o32_ovf, o32_zero;

  logic        i16_valid, i16_rdy, o16_in_ready, o16_valid;
  logic [1:0]  i16_op;
  logic [15:0] i16_a, i16_b, o16_res;
  logic        o16_cout, o16_ovf, o16_zero;

  addsub_pipe #(.N(32), .SEG(8)) dut32 (
    .i_clk(clk), .i_rst(rst),
    .i_in_valid(i32_valid), .o_in_ready(o32_in_ready), .i_in_op(i32_op),
    .i_in_a(i32_a), .i_in_b(i32_b),
    .o_out_valid(o32_valid), .i_out_ready(i32_rdy), .o_out_res(o32_res),
    .o_out_cout(o32_cout), .o_out_ovf(o32_ovf), .o_out_zero(o32_zero)
  );

  addsub_pipe #(.N(16), .SEG(4)) dut16 (
    .i_clk(clk), .i_rst(rst),
    .i_in_valid(i16_valid), .o_in_ready(o16_in_ready), .i_in_op(i16_op),
    .i_in_a(i16_a), .i_in_b(i16_b),
    .o_out_valid(o16_valid), .i_out_ready(i16_rdy), .o_out_res(o16_res),
    .o_out_cout(o16_cout), .o_out_ovf(o16_ovf), .o_out_zero(o16_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // {res, cout, ovf, zero}
  typedef struct packed {
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int n);
    longint unsigned mask, ua, ub, full;
    longint sa, sb, r, smax, smin;
    exp_t e;
    mask = (64'd1 << n) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sa   = (((ua >> (n - 1)) & 64'd1) != 0) ? longint'(ua) - longint'(mask + 1) : longint'(ua);
    sb   = (((ub >> (n - 1)) & 64'd1) != 0) ? longint'(ub) - longint'(mask + 1) : longint'(ub);
    smax = longint'(mask >> 1);
    smin = -smax - 1;
    e    = '0;
    case (op)
      2'b00: begin
        full   = ua + ub;
        e.res  = 32'(full & mask);
        e.cout = ((full >> n) & 64'd1) != 0;
        r      = sa + sb;
        e.ovf  = (r > smax) || (r < smin);
      end
      2'b01: begin
        e.res  = 32'((ua - ub) & mask);
        e.cout = (ua >= ub);
        r      = sa - sb;
        e.ovf  = (r > smax) || (r < smin);
      end
      2'b10:   e.res = {31'd0, ua == ub};
      default: e.res = {31'd0, sa > sb};
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Scoreboards: expected results pushed on accept, popped on drain.
  exp_t        q32[$];
  exp_t        q16[$];
  bit          mon32_en, mon16_en;
  int          pop32, pop16;
  logic        stall32_q, stall16_q;
  logic [34:0] held32, held16;

  always @(negedge clk) begin
    if (rst) begin
      q32.delete();
      stall32_q <= 1'b0;
    end else if (mon32_en) begin
      if (stall32_q) check("stall32_hold", {o32_res, o32_cout, o32_ovf, o32_zero}, held32);
      if (o32_valid && !i32_rdy) check("stall32_in_ready", o32_in_ready, 0);
      if (i32_valid && o32_in_ready) q32.push_back(model(i32_op, i32_a, i32_b, 32));
      if (o32_valid && i32_rdy) begin
        if (q32.size() == 0) check("sb32_unexpected", 1, 0);
        else begin
          check("sb32_res", o32_res, q32[0].res);
          check("sb32_cout", o32_cout, q32[0].cout);
          check("sb32_ovf", o32_ovf, q32[0].ovf);
          check("sb32_zero", o32_zero, q32[0].zero);
          q32.pop_front();
          pop32 <= pop32 + 1;
        end
      end
      stall32_q <= o32_valid && !i32_rdy;
      held32    <= {o32_res, o32_cout, o32_ovf, o32_zero};
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q16.delete();
      stall16_q <= 1'b0;
    end else if (mon16_en) begin
      if (stall16_q) check("stall16_hold", {16'd0, o16_res, o16_cout, o16_ovf, o16_zero}, held16);
      if (o16_valid && !i16_rdy) check("stall16_in_ready", o16_in_ready, 0);
      if (i16_valid && o16_in_ready) q16.push_back(model(i16_op, {16'd0, i16_a}, {16'd0, i16_b}, 16));
      if (o16_valid && i16_rdy) begin
        if (q16.size() == 0) check("sb16_unexpected", 1, 0);
        else begin
          check("sb16_res", {16'd0, o16_res}, q16[0].res);
          check("sb16_cout", o16_cout, q16[0].cout);
          check("sb16_ovf", o16_ovf, q16[0].ovf);
          check("sb16_zero", o16_zero, q16[0].zero);
          q16.pop_front();
          pop16 <= pop16 + 1;
        end
      end
      stall16_q <= o16_valid && !i16_rdy;
      held16    <= {16'd0, o16_res, o16_cout, o16_ovf, o16_zero};
    end
  end

  // Issue one beat into an idle pipeline and wait (bounded) for its result.
  task automatic issue_one(input bit sel16, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, output int lat, output logic [34:0] got);
    if (sel16) begin
      i16_valid = 1'b1; i16_op = op; i16_a = a[15:0]; i16_b = b[15:0];
    end else begin
      i32_valid = 1'b1; i32_op = op; i32_a = a; i32_b = b;
    end
    @(posedge clk); #1;
    i16_valid = 1'b0;
    i32_valid = 1'b0;
    lat = 1;
    while (!(sel16 ? o16_valid : o32_valid) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    got = sel16 ? {16'd0, o16_res, o16_cout, o16_ovf, o16_zero}
                : {o32_res, o32_cout, o32_ovf, o32_zero};
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  int          lat, idx, sent, rsel;
  logic [34:0] got;
  bit          acc;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{OP_ADD, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0, 1'b1};
    vecs[1] = '{OP_ADD, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{OP_SUB, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{OP_GT,  32'h5,         32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b0};
    vecs[4] = '{OP_GT,  32'hFFFF_FFFF, 32'h5,         32'h0,         1'b0, 1'b0, 1'b1};
    vecs[5] = '{OP_EQ,  32'h1234,      32'h1234,      32'h1,         1'b0, 1'b0, 1'b0};
    vecs[6] = '{OP_GT,  32'h7,         32'h7,         32'h0,         1'b0, 1'b0, 1'b1};
    vecs[7] = '{OP_SUB, 32'h5,         32'h7,         32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{OP_EQ,  32'h1,         32'h2,         32'h0,         1'b0, 1'b0, 1'b1};
    vecs[9] = '{OP_ADD, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    i32_valid = 0; i32_op = 0; i32_a = 0; i32_b = 0; i32_rdy = 1;
    i16_valid = 0; i16_op = 0; i16_a = 0; i16_b = 0; i16_rdy = 1;
    mon32_en = 0; mon16_en = 0; pop32 = 0; pop16 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("reset_out_valid32", o32_valid, 0);
    check("reset_in_ready32", o32_in_ready, 1);
    check("reset_outputs32", {o32_res, o32_cout, o32_ovf, o32_zero}, 0);
    check("reset_out_valid16", o16_valid, 0);
    check("reset_in_ready16", o16_in_ready, 1);

    // Directed vectors
    for (int i = 0; i < NV; i++) begin
      issue_one(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, lat, got);
      check($sformatf("vec%0d_latency", i), lat, 4);
      check($sformatf("vec%0d_res", i), got[34:3], vecs[i].res);
      check($sformatf("vec%0d_cout", i), got[2], vecs[i].cout);
      check($sformatf("vec%0d_ovf", i), got[1], vecs[i].ovf);
      check($sformatf("vec%0d_zero", i), got[0], vecs[i].zero);
      @(posedge clk); #1;
    end

    // Back-to-back stream of 8 with a 3-cycle output stall mid-stream
    mon32_en = 1; pop32 = 0; idx = 0; acc = 0;
    for (int c = 0; c < 200; c++) begin
      if (acc) idx++;
      if (idx >= 8) break;
      if (acc || !i32_valid) begin
        i32_valid = 1'b1;
        i32_op    = 2'($urandom_range(0, 3));
        i32_a     = $urandom;
        i32_b     = $urandom;
      end
      i32_rdy = !(c >= 5 && c <= 7);
      @(negedge clk);
      acc = i32_valid && o32_in_ready;
      @(posedge clk); #1;
    end
    i32_valid = 1'b0;
    i32_rdy   = 1'b1;
    for (int w = 0; w < 50 && (q32.size() != 0 || o32_valid); w++) begin
      @(posedge clk); #1;
    end
    check("stream32_count", pop32, 8);
    mon32_en = 0;

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      i32_valid = 1'b1; i32_op = OP_ADD; i32_a = 32'(i + 1); i32_b = 32'h100;
      @(posedge clk); #1;
    end
    i32_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_async_valid", o32_valid, 0);
    check("rst_in_ready", o32_in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("post_rst_valid%0d", i), o32_valid, 0);
      @(posedge clk); #1;
    end
    issue_one(1'b0, OP_SUB, 32'd10, 32'd3, lat, got);
    check("post_rst_latency", lat, 4);
    check("post_rst_result", got, model(OP_SUB, 32'd10, 32'd3, 32));
    @(posedge clk); #1;

    // N=16 SEG=4 instance: directed latency, then random sweep with bubbles and stalls
    issue_one(1'b1, OP_ADD, 32'hFFFF, 32'h1, lat, got);
    check("n16_latency", lat, 4);
    check("n16_add_wrap", got, {16'd0, 16'h0, 1'b1, 1'b0, 1'b1});
    @(posedge clk); #1;
    issue_one(1'b1, OP_GT, 32'h8000, 32'h7FFF, lat, got);
    check("n16_gt_latency", lat, 4);
    check("n16_gt_neg", got, {16'd0, 16'h0, 1'b0, 1'b0, 1'b1});
    @(posedge clk); #1;

    mon16_en = 1; pop16 = 0; sent = 0; acc = 0;
    for (int guard = 0; guard < 20000; guard++) begin
      if (acc) sent++;
      if (sent >= 1000) break;
      if (acc || !i16_valid) begin
        if ($urandom_range(0, 3) != 0) begin
          rsel      = int'($urandom_range(0, 2));
          i16_valid = 1'b1;
          i16_op    = (rsel == 2) ? OP_GT : 2'(rsel);
          i16_a     = 16'($urandom);
          i16_b     = 16'($urandom);
        end else begin
          i16_valid = 1'b0;
        end
      end
      i16_rdy = ($urandom_range(0, 9) != 0);
      @(negedge clk);
      acc = i16_valid && o16_in_ready;
      @(posedge clk); #1;
    end
    i16_valid = 1'b0;
    i16_rdy   = 1'b1;
    for (int w = 0; w < 50 && (q16.size() != 0 || o16_valid); w++) begin
      @(posedge clk); #1;
    end
    check("sweep16_accepted", sent, 1000);
    check("sweep16_count", pop16, 1000);
    mon16_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
